// File: rtl/muladd_arb_pkg.sv
// ============================================================================
// Module   : muladd_arb_pkg
// Purpose  : Shared widths and operation/result bundles for the muladd
//            round-robin scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package muladd_arb_pkg;

  localparam int MU_DW  = 64;  // IEEE-754 double operand/result width
  localparam int HTID_W = 9;   // hardware thread ID width

  // One operation as issued to the muladd unit (a + b*c)
  typedef struct packed {
    logic [MU_DW-1:0]  a;
    logic [MU_DW-1:0]  b;
    logic [MU_DW-1:0]  c;
    logic [HTID_W-1:0] htId;
  } mu_op_t;

  // One result as returned by the muladd unit
  typedef struct packed {
    logic [MU_DW-1:0]  res;
    logic [HTID_W-1:0] htId;
  } mu_res_t;

endpackage

`default_nettype wire

// File: rtl/muladd_arb_tagq.sv
// ============================================================================
// Module   : muladd_arb_tagq
// Purpose  : In-order tag FIFO holding the requester index of each operation
//            in flight. Pointers carry one extra MSB to tell full from empty.
//            Push while full and pop while empty are ignored.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muladd_arb_tagq
  import muladd_arb_pkg::*;
#(
  parameter int DEPTH = 32,  // power of two, >= 2
  parameter int W     = 2
) (
  input  logic         ck,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q;
  logic [AW:0]  rptr_q;
  logic         w_push;
  logic         w_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  // Storage: entries are only read while valid, so they need no reset
  always_ff @(posedge ck) begin
    if (w_push) begin
      mem_q[wptr_q[AW-1:0]] <= push_data_i;
    end
  end

  // Read/write pointers; reset discards every queued tag
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (w_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (w_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/muladd_arb.sv
// ============================================================================
// Module   : muladd_arb
// Purpose  : Round-robin scheduler sharing one muladd unit (a + b*c) among
//            NREQ requesters. Bounds operations in flight, tags each issue
//            with its requester and steers in-order results back.
// Options  : MULADD_ARB_STATS_EN - adds per-requester 32-bit grant counters
//            on o_issue_cnt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muladd_arb
  import muladd_arb_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int MAX_OUT = 32,
  localparam int RW      = $clog2(NREQ)
) (
  input  logic                     ck,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          i_req_vld,
  input  logic [NREQ*MU_DW-1:0]    i_req_a,
  input  logic [NREQ*MU_DW-1:0]    i_req_b,
  input  logic [NREQ*MU_DW-1:0]    i_req_c,
  input  logic [NREQ*HTID_W-1:0]   i_req_htId,
  output logic [NREQ-1:0]          o_req_rdy,
  output logic [MU_DW-1:0]         o_mu_a,
  output logic [MU_DW-1:0]         o_mu_b,
  output logic [MU_DW-1:0]         o_mu_c,
  output logic [HTID_W-1:0]        o_mu_htId,
  output logic                     o_mu_vld,
  input  logic                     i_mu_rdy,
  input  logic [MU_DW-1:0]         i_mu_res,
  input  logic [HTID_W-1:0]        i_mu_htId,
  input  logic                     i_mu_vld,
  output logic [MU_DW-1:0]         o_res,
  output logic [HTID_W-1:0]        o_res_htId,
  output logic [NREQ-1:0]          o_res_vld,
  output logic                     o_busy,
  output logic                     o_err
`ifdef MULADD_ARB_STATS_EN
  ,
  output logic [NREQ*32-1:0]       o_issue_cnt
`endif
);

  localparam int            CW         = $clog2(MAX_OUT) + 1;
  localparam logic [CW-1:0] C_MAX_OUT  = CW'(MAX_OUT);
  localparam logic [RW-1:0] C_LAST_RST = RW'(NREQ - 1);

  logic [RW-1:0]   last_q;
  logic [CW-1:0]   out_cnt_q;
  logic [CW-1:0]   out_cnt_d;
  mu_op_t          mu_op_q;
  logic            mu_vld_q;
  mu_res_t         res_q;
  logic [NREQ-1:0] res_vld_q;
  logic            busy_q;
  logic            err_q;

  logic            w_elig;
  logic            w_gnt;
  logic [RW-1:0]   w_gnt_idx;
  mu_op_t          w_sel_op;
  logic [RW-1:0]   w_tag_head;
  logic            w_tag_empty;
  logic            w_tag_full;
  logic            w_pop;

  // Tag FIFO is full exactly when out_cnt hits MAX_OUT; both are checked
  assign w_elig = i_mu_rdy & (out_cnt_q < C_MAX_OUT) & ~w_tag_full;
  assign w_pop  = i_mu_vld & ~w_tag_empty;

  // Round-robin search starting one past the last granted requester
  always_comb begin
    w_gnt     = 1'b0;
    w_gnt_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_gnt && w_elig && i_req_vld[(int'(last_q) + k) % NREQ]) begin
        w_gnt     = 1'b1;
        w_gnt_idx = RW'((int'(last_q) + k) % NREQ);
      end
    end
  end

  assign o_req_rdy = w_gnt ? (NREQ'(1) << w_gnt_idx) : '0;

  // Operand slice of the granted requester
  always_comb begin
    w_sel_op.a    = i_req_a[w_gnt_idx*MU_DW +: MU_DW];
    w_sel_op.b    = i_req_b[w_gnt_idx*MU_DW +: MU_DW];
    w_sel_op.c    = i_req_c[w_gnt_idx*MU_DW +: MU_DW];
    w_sel_op.htId = i_req_htId[w_gnt_idx*HTID_W +: HTID_W];
  end

  // Priority pointer moves only when something is granted
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= C_LAST_RST;
    end else if (w_gnt) begin
      last_q <= w_gnt_idx;
    end
  end

  // Issue register: one-cycle valid pulse per grant, data held otherwise
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      mu_op_q  <= '0;
      mu_vld_q <= 1'b0;
    end else begin
      mu_vld_q <= w_gnt;
      if (w_gnt) begin
        mu_op_q <= w_sel_op;
      end
    end
  end

  // Outstanding count: a spurious result (empty FIFO) never decrements
  always_comb begin
    out_cnt_d = out_cnt_q;
    case ({w_gnt, w_pop})
      2'b10:   out_cnt_d = out_cnt_q + CW'(1);
      2'b01:   out_cnt_d = out_cnt_q - CW'(1);
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  // Outstanding counter and busy flag reflecting the updated count
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      out_cnt_q <= out_cnt_d;
      busy_q    <= (out_cnt_d != '0);
    end
  end

  // Result register steered by the tag FIFO head; sticky error on orphans
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      res_q     <= '0;
      res_vld_q <= '0;
      err_q     <= 1'b0;
    end else begin
      res_vld_q <= w_pop ? (NREQ'(1) << w_tag_head) : '0;
      if (i_mu_vld) begin
        res_q.res  <= i_mu_res;
        res_q.htId <= i_mu_htId;
      end
      if (i_mu_vld && w_tag_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  muladd_arb_tagq #(
    .DEPTH (MAX_OUT),
    .W     (RW)
  ) u_tagq (
    .ck          (ck),
    .rst_n       (rst_n),
    .push_i      (w_gnt),
    .push_data_i (w_gnt_idx),
    .pop_i       (i_mu_vld),
    .head_o      (w_tag_head),
    .empty_o     (w_tag_empty),
    .full_o      (w_tag_full)
  );

  assign o_mu_a     = mu_op_q.a;
  assign o_mu_b     = mu_op_q.b;
  assign o_mu_c     = mu_op_q.c;
  assign o_mu_htId  = mu_op_q.htId;
  assign o_mu_vld   = mu_vld_q;
  assign o_res      = res_q.res;
  assign o_res_htId = res_q.htId;
  assign o_res_vld  = res_vld_q;
  assign o_busy     = busy_q;
  assign o_err      = err_q;

`ifdef MULADD_ARB_STATS_EN
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_stats
    logic [31:0] issue_cnt_q;

    // Per-requester grant counter, wraps naturally at 2^32
    always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
        issue_cnt_q <= '0;
      end else if (o_req_rdy[gi]) begin
        issue_cnt_q <= issue_cnt_q + 32'd1;
      end
    end

    assign o_issue_cnt[gi*32 +: 32] = issue_cnt_q;
  end
`endif

endmodule

`default_nettype wire
